// File: rtl/piano_poly_envelope_pkg.sv
// Shared definitions for the polyphonic piano: per-key half-period table,
// voice state encoding and the envelope ceiling helper.
package pianissimo_audio_pkg;

    // C4..E5 half periods in CLOCK_50 cycles
    localparam int HALF_PERIOD [10] = '{95554, 85132, 75842, 71586, 63775,
                                        56818, 50620, 47778, 42568, 37922};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2
    } voice_state_t;

    function automatic int env_max(input int env_w);
        return (1 << env_w) - 1;
    endfunction

endpackage

// File: rtl/piano_poly_envelope_voice.sv
// One piano voice: key edge detection, IDLE/HOLD/RELEASE envelope FSM,
// square-wave oscillator and the signed contribution to the mix.
module piano_voice
    import pianissimo_audio_pkg::*;
#(
    parameter int HALF_PERIOD_CYC = 95554,
    parameter int ENV_W           = 8,
    parameter int SUSTAIN_LVL     = 64,
    parameter int AMP_UNIT        = 4096,
    parameter int SUM_W           = 36
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    key,
    input  logic                    hold_tick,
    input  logic                    rel_tick,
    output logic signed [SUM_W-1:0] contrib,
    output logic                    active
);

    localparam int CNT_W = (HALF_PERIOD_CYC > 1) ? $clog2(HALF_PERIOD_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD_CYC - 1);
    localparam logic [ENV_W-1:0] ENV_TOP  = ENV_W'(env_max(ENV_W));
    localparam logic [ENV_W-1:0] ENV_SUS  = ENV_W'(SUSTAIN_LVL);
    localparam logic signed [SUM_W-1:0] AMP = SUM_W'(AMP_UNIT);

    voice_state_t     state, state_nxt;
    logic             key_q;
    logic [ENV_W-1:0] env, env_nxt;
    logic             phase, phase_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             press, release_evt;
    logic signed [SUM_W-1:0] mag;

    assign press       = key & ~key_q;
    assign release_evt = ~key & key_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            key_q  <= 1'b0;
            env    <= '0;
            phase  <= 1'b0;
            cnt    <= '0;
            active <= 1'b0;
        end else begin
            state  <= state_nxt;
            key_q  <= key;
            env    <= env_nxt;
            phase  <= phase_nxt;
            cnt    <= cnt_nxt;
            active <= (state != IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        env_nxt   = env;
        phase_nxt = phase;
        cnt_nxt   = cnt;
        if (state != IDLE) begin
            if (cnt == CNT_LAST) begin
                cnt_nxt   = '0;
                phase_nxt = ~phase;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
        // A press always restarts the note, even when a tick lands on the same cycle
        case (state)
            IDLE: begin
                if (press) begin
                    state_nxt = HOLD;
                    env_nxt   = ENV_TOP;
                    phase_nxt = 1'b0;
                    cnt_nxt   = '0;
                end
            end
            HOLD: begin
                if (release_evt) begin
                    state_nxt = RELEASE;
                end else if (hold_tick && (env > ENV_SUS)) begin
                    env_nxt = env - ENV_W'(1);
                end
            end
            RELEASE: begin
                if (press) begin
                    state_nxt = HOLD;
                    env_nxt   = ENV_TOP;
                    phase_nxt = 1'b0;
                    cnt_nxt   = '0;
                end else if (env == '0) begin
                    state_nxt = IDLE;
                end else if (rel_tick) begin
                    env_nxt = env - ENV_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mag = $signed({{(SUM_W-ENV_W){1'b0}}, env}) * AMP;

    always_comb begin
        contrib = '0;
        if (state != IDLE) begin
            contrib = phase ? mag : -mag;
        end
    end

endmodule

// File: rtl/piano_poly_envelope.sv
// Polyphonic piano top: one voice per key, shared envelope prescalers,
// saturating mix register and the Audio_Controller write handshake.
module piano_poly_envelope
    import pianissimo_audio_pkg::*;
#(
    parameter int NUM_KEYS    = 10,
    parameter int SAMPLE_W    = 32,
    parameter int ENV_W       = 8,
    parameter int SUSTAIN_LVL = 64,
    parameter int AMP_UNIT    = 4096,
    parameter int HOLD_DIV    = 256,
    parameter int REL_DIV     = 16
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic [NUM_KEYS-1:0]        keys_i,
    input  logic                       audio_out_allowed,
    output logic                       write_audio_out,
    output logic signed [SAMPLE_W-1:0] left_channel_audio_out,
    output logic signed [SAMPLE_W-1:0] right_channel_audio_out,
    output logic [NUM_KEYS-1:0]        voice_active
);

    localparam int SUM_W  = SAMPLE_W + $clog2(NUM_KEYS);
    localparam int HOLD_W = (HOLD_DIV > 1) ? $clog2(HOLD_DIV) : 1;
    localparam int REL_W  = (REL_DIV > 1) ? $clog2(REL_DIV) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_DIV - 1);
    localparam logic [REL_W-1:0]  REL_LAST  = REL_W'(REL_DIV - 1);
    localparam logic signed [SUM_W-1:0] SAT_HI =
        {{(SUM_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_LO =
        {{(SUM_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    function automatic logic signed [SAMPLE_W-1:0] saturate(input logic signed [SUM_W-1:0] x);
        if (x > SAT_HI)      return SAT_HI[SAMPLE_W-1:0];
        else if (x < SAT_LO) return SAT_LO[SAMPLE_W-1:0];
        else                 return x[SAMPLE_W-1:0];
    endfunction

    logic [HOLD_W-1:0]       hold_cnt;
    logic [REL_W-1:0]        rel_cnt;
    logic                    hold_tick, rel_tick;
    logic signed [SUM_W-1:0] contrib [NUM_KEYS];
    logic signed [SUM_W-1:0] sum_p0;
    logic signed [SAMPLE_W-1:0] sample_p1;

    assign write_audio_out = audio_out_allowed & ~reset;
    assign hold_tick       = write_audio_out & (hold_cnt == HOLD_LAST);
    assign rel_tick        = write_audio_out & (rel_cnt == REL_LAST);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            hold_cnt <= '0;
            rel_cnt  <= '0;
        end else if (write_audio_out) begin
            hold_cnt <= hold_tick ? '0 : hold_cnt + HOLD_W'(1);
            rel_cnt  <= rel_tick  ? '0 : rel_cnt + REL_W'(1);
        end
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_voice
        piano_voice #(
            .HALF_PERIOD_CYC(HALF_PERIOD[k]),
            .ENV_W          (ENV_W),
            .SUSTAIN_LVL    (SUSTAIN_LVL),
            .AMP_UNIT       (AMP_UNIT),
            .SUM_W          (SUM_W)
        ) u_voice (
            .clk      (CLOCK_50),
            .reset    (reset),
            .key      (keys_i[k]),
            .hold_tick(hold_tick),
            .rel_tick (rel_tick),
            .contrib  (contrib[k]),
            .active   (voice_active[k])
        );
    end

    // Stage p0: wide signed sum of all voices
    always_comb begin
        sum_p0 = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            sum_p0 = sum_p0 + contrib[k];
        end
    end

    // Stage p1: saturated, registered sample
    always_ff @(posedge CLOCK_50) begin
        if (reset) sample_p1 <= '0;
        else       sample_p1 <= saturate(sum_p0);
    end

    assign left_channel_audio_out  = sample_p1;
    assign right_channel_audio_out = sample_p1;

endmodule
